// File: rtl/instruction_fetcher_pkg.sv
// Shared constants and state encoding for the fetch stage and its JAL predecoder
// (the predecoder exists only when FETCH_JAL_PREDICT_EN is defined).
package instruction_fetcher_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [6:0]  OPC_JAL          = 7'b1101111;
    localparam int          ICACHE_SIZE_BIT  = 8;

    typedef enum logic {
        FETCH = 1'b0,
        MISS  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetcher_predecode.sv
// Combinational JAL detect and target computation; built only under FETCH_JAL_PREDICT_EN.
// Zero latency, no flow control.
`ifdef FETCH_JAL_PREDICT_EN
module instruction_fetcher_predecode
    import instruction_fetcher_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [31:0]       word,
    input  logic [ADDR_W-1:0] pc,
    output logic              is_jal,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] imm;
    logic              unused_rd;

    assign is_jal    = (word[6:0] == OPC_JAL);
    // J-type immediate: 21-bit signed, bit 0 implicitly zero
    assign imm       = ADDR_W'({{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0});
    assign target    = pc + imm;
    assign unused_rd = ^word[11:7];

endmodule
`endif

// File: rtl/instruction_fetcher.sv
// Fetch stage in front of the I-cache: 1-cycle hit latency, miss delivers 2 cycles after mem_done;
// output register holds under inst_ready=0, rdy_in=0 freezes all state. JAL prediction via FETCH_JAL_PREDICT_EN.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    output logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_hit,
    input  logic [31:0]       ic_res,
    output logic              ic_we,
    output logic [31:0]       ic_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_done,
    input  logic [31:0]       mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              pend_q, pend_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;

    logic              adv;
    logic              fill;
    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] seq_pc;
    logic              unused_redirect_lsbs;

    assign redir_tgt            = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign adv                  = !inst_valid_q || inst_ready;
    assign fill                 = rst_in && rdy_in && (state_q == MISS) && mem_done;

`ifdef FETCH_JAL_PREDICT_EN
    logic              is_jal;
    logic [ADDR_W-1:0] jal_tgt;

    instruction_fetcher_predecode #(.ADDR_W(ADDR_W)) u_predecode (
        .word   (ic_res),
        .pc     (pc_q),
        .is_jal (is_jal),
        .target (jal_tgt)
    );

    assign seq_pc = is_jal ? jal_tgt : pc_q + ADDR_W'(4);
`else
    assign seq_pc = pc_q + ADDR_W'(4);
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        pend_d       = pend_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    pc_d         = redir_tgt;
                    inst_valid_d = 1'b0;
                end else if (adv) begin
                    if (ic_hit) begin
                        inst_d       = ic_res;
                        inst_pc_d    = pc_q;
                        inst_valid_d = 1'b1;
                        pc_d         = seq_pc;
                    end else begin
                        mem_req_d    = 1'b1;
                        mem_addr_d   = pc_q;
                        state_d      = MISS;
                        inst_valid_d = 1'b0;
                    end
                end
            end
            MISS: begin
                // The memory transaction cannot be cancelled; park redirects until the fill lands.
                if (redirect_valid) begin
                    pend_pc_d    = redir_tgt;
                    pend_d       = 1'b1;
                    inst_valid_d = 1'b0;
                end
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    state_d   = FETCH;
                    pend_d    = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redir_tgt;
                    end else if (pend_q) begin
                        pc_d = pend_pc_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_pc_q    <= pend_pc_d;
            pend_q       <= pend_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign ic_addr    = (state_q == MISS) ? mem_addr_q : pc_q;
    assign ic_we      = fill;
    assign ic_data    = fill ? mem_data : 32'h0;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: cache/memory models plus an architectural instruction-stream reference.
module tb_instruction_fetcher;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in, rdy_in, inst_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_done = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic [31:0] ic_addr, ic_res, ic_data, mem_addr, inst, inst_pc;
    logic        ic_hit, ic_we, mem_req, inst_valid;

    int n_vec = 0;
    int n_err = 0;
    int we_cnt = 0;
    int resp_lat = 0;
    int lat_cnt = 0;

    // Direct-mapped cache model, full address kept as tag
    logic        cval [256];
    logic [31:0] ctag [256];
    logic [31:0] cdat [256];

    assign ic_hit = cval[ic_addr[9:2]] && (ctag[ic_addr[9:2]] == ic_addr);
    assign ic_res = cdat[ic_addr[9:2]];

    instruction_fetcher #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .ic_addr(ic_addr), .ic_hit(ic_hit), .ic_res(ic_res),
        .ic_we(ic_we), .ic_data(ic_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
    );

    // Backing store: word 0 is a NOP, 0x20 is JAL x0,+16, everything else a non-JAL hash
    function automatic logic [31:0] backing(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0000_0000) return 32'h0000_0013;
        if (a == 32'h0000_0020) return 32'h0100_006F;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        return {h[31:7], 7'b0010011};
    endfunction

`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    // Address of the instruction that architecturally follows word w at pc
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w);
        int off;
        if (JAL_EN && w[6:0] == 7'b1101111) begin
            off = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - (w[31] ? 1048576 : 0);
            return pc + 32'(off);
        end
        return pc + 32'd4;
    endfunction

    // Memory controller: mem_done resp_lat cycles after mem_req, repeats while mem_req stays high
    always @(posedge clk_in) begin
        #2;
        mem_done = 1'b0;
        if (mem_req === 1'b1 && resp_lat > 0) begin
            if (lat_cnt >= resp_lat) begin
                mem_done = 1'b1;
                mem_data = backing(mem_addr);
                lat_cnt  = 0;
            end else begin
                lat_cnt = lat_cnt + 1;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    task automatic step();
        @(negedge clk_in);
        n_vec++;
        if (ic_addr[1:0] !== 2'b00) begin
            n_err++; $display("FAIL ic_addr_align got %h want low bits 00", ic_addr);
        end
        if (ic_we === 1'b1) begin
            n_vec++;
            if (mem_done !== 1'b1 || ic_data !== backing(ic_addr)) begin
                n_err++; $display("FAIL fill_data addr %h got %h done %b want %h", ic_addr, ic_data, mem_done, backing(ic_addr));
            end
            we_cnt++;
            cval[ic_addr[9:2]] = 1'b1;
            ctag[ic_addr[9:2]] = ic_addr;
            cdat[ic_addr[9:2]] = ic_data;
        end
    endtask

    task automatic clear_cache();
        for (int i = 0; i < 256; i++) begin
            cval[i] = 1'b0; ctag[i] = 32'h0; cdat[i] = 32'h0;
        end
    endtask

    task automatic preload(input logic [31:0] a);
        cval[a[9:2]] = 1'b1; ctag[a[9:2]] = a; cdat[a[9:2]] = backing(a);
    endtask

    task automatic do_reset();
        rst_in = 1'b0; rdy_in = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        rst_in = 1'b1;
    endtask

    task automatic wait_valid(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            step();
            if (inst_valid === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_cache(); resp_lat = 0; inst_ready = 1'b0;
        rst_in = 1'b0; rdy_in = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
        n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", inst); end
        n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
        n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_vec++; if (ic_we !== 1'b0 || ic_data !== 32'h0) begin n_err++; $display("FAIL reset_ic_we got %b/%h want 0/0", ic_we, ic_data); end
        n_vec++; if (ic_addr !== RST_PC) begin n_err++; $display("FAIL reset_pc got %h want %h", ic_addr, RST_PC); end
    endtask

    task automatic test_cold_start();
        int  we0;
        bit  found;
        resp_lat = 5; inst_ready = 1'b0; we0 = we_cnt;
        rst_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (ic_we === 1'b1) found = 1'b1;
        end
        n_vec++; if (!found) begin n_err++; $display("FAIL cold_fill got no ic_we want one within 40 cycles"); end
        n_vec++; if (mem_addr !== 32'h0 || ic_data !== 32'h13) begin n_err++; $display("FAIL cold_fill_word got %h@%h want 13@0", ic_data, mem_addr); end
        step();
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL cold_early_valid got %b want 0", inst_valid); end
        step();
        n_vec++; if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h0) begin
            n_err++; $display("FAIL cold_deliver got v%b %h@%h want v1 13@0", inst_valid, inst, inst_pc);
        end
        step(); step();
        n_vec++; if (we_cnt - we0 != 1 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL cold_single_fill got %0d fills req %b want 1 fill req 0", we_cnt - we0, mem_req);
        end
    endtask

    task automatic test_hit_stream();
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) preload(32'(i * 4));
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(i * 4) || inst !== backing(32'(i * 4)) || mem_req !== 1'b0) begin
                n_err++; $display("FAIL hit_stream[%0d] got v%b %h@%h req %b want v1 %h@%h req 0",
                                  i, inst_valid, inst, inst_pc, mem_req, backing(32'(i * 4)), i * 4);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        preload(32'h0); preload(32'h4);
        do_reset();
        step(); step();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin n_err++; $display("FAIL bp_setup got v%b @%h want v1 @4", inst_valid, inst_pc); end
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== backing(32'h4) || ic_addr !== 32'h8 || mem_req !== 1'b0) begin
                n_err++; $display("FAIL bp_hold[%0d] got v%b %h@%h pc %h req %b want v1 %h@4 pc 8 req 0",
                                  i, inst_valid, inst, inst_pc, ic_addr, mem_req, backing(32'h4));
            end
        end
        inst_ready = 1'b1;
        step();
        n_vec++; if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_err++; $display("FAIL bp_release got v%b req %b addr %h want v0 req 1 addr 8", inst_valid, mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_miss();
        bit found;
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        step();
        n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin n_err++; $display("FAIL rm_miss got req %b addr %h want 1/40", mem_req, mem_addr); end
        resp_lat = 3;
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (ic_we === 1'b1) found = 1'b1;
        end
        n_vec++; if (!found || ic_addr !== 32'h40) begin n_err++; $display("FAIL rm_fill got found %b addr %h want fill at 40", found, ic_addr); end
        step();
        n_vec++; if (ic_addr !== 32'h100) begin n_err++; $display("FAIL rm_lookup got %h want 100", ic_addr); end
        wait_valid(30, found);
        n_vec++; if (!found || inst_pc !== 32'h100 || inst !== backing(32'h100)) begin
            n_err++; $display("FAIL rm_deliver got v%b %h@%h want %h@100", found, inst, inst_pc, backing(32'h100));
        end
    endtask

    task automatic test_rdy_freeze();
        int we0;
        bit seen, found;
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        do_reset();
        step();
        resp_lat = 2; rdy_in = 1'b0; we0 = we_cnt; seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_done === 1'b1) seen = 1'b1;
            n_vec++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0 || ic_addr !== 32'h0 || inst_valid !== 1'b0 || ic_we !== 1'b0) begin
                n_err++; $display("FAIL rdy_hold[%0d] got req %b addr %h ic %h v%b we %b want 1 0 0 v0 we0",
                                  i, mem_req, mem_addr, ic_addr, inst_valid, ic_we);
            end
        end
        n_vec++; if (!seen || we_cnt != we0) begin n_err++; $display("FAIL rdy_done_ignored got done %b fills %0d want done 1 fills 0", seen, we_cnt - we0); end
        rdy_in = 1'b1;
        wait_valid(20, found);
        n_vec++; if (!found || inst_pc !== 32'h0 || inst !== 32'h13 || we_cnt - we0 != 1) begin
            n_err++; $display("FAIL rdy_resume got v%b %h@%h fills %0d want 13@0 fills 1", found, inst, inst_pc, we_cnt - we0);
        end
    endtask

    task automatic test_reset_mid_miss();
        bit found;
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        redirect_valid = 1'b0;
        step();
        resp_lat = 4;
        step(); step();
        rst_in = 1'b0;
        step();
        n_vec++; if (mem_req !== 1'b0 || inst_valid !== 1'b0 || ic_addr !== RST_PC || mem_addr !== 32'h0) begin
            n_err++; $display("FAIL rst_mid_miss got req %b v%b pc %h addr %h want 0 v0 %h 0", mem_req, inst_valid, ic_addr, mem_addr, RST_PC);
        end
        rst_in = 1'b1;
        wait_valid(30, found);
        n_vec++; if (!found || inst_pc !== RST_PC || inst !== backing(RST_PC)) begin
            n_err++; $display("FAIL rst_restart got v%b %h@%h want %h@%h", found, inst, inst_pc, backing(RST_PC), RST_PC);
        end
    endtask

    task automatic test_jal();
        logic [31:0] want;
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        preload(32'h20); preload(32'h24); preload(32'h30);
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        step();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h20) begin n_err++; $display("FAIL jal_first got v%b @%h want v1 @20", inst_valid, inst_pc); end
        want = next_pc(32'h20, backing(32'h20));
        step();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== want) begin n_err++; $display("FAIL jal_next got v%b @%h want v1 @%h", inst_valid, inst_pc, want); end
    endtask

    task automatic test_wrap();
        clear_cache(); resp_lat = 0; inst_ready = 1'b1;
        preload(32'hFFFF_FFFC); preload(32'h0);
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        step();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top got v%b @%h want v1 @fffffffc", inst_valid, inst_pc); end
        step();
        n_vec++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h13) begin
            n_err++; $display("FAIL wrap_zero got v%b %h@%h want v1 13@0", inst_valid, inst, inst_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        int          xfers;
        clear_cache();
        for (int i = 0; i < 256; i++) if ($urandom_range(1, 0) == 1) preload(32'(i * 4));
        resp_lat = 2; inst_ready = 1'b1;
        do_reset();
        exp_pc = RST_PC; xfers = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) resp_lat = $urandom_range(4, 1);
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = $urandom_range(32'h3FF, 0);
            if (inst_valid === 1'b1 && inst_ready) begin
                n_vec++;
                if (inst_pc !== exp_pc || inst !== backing(exp_pc)) begin
                    n_err++; $display("FAIL rand_stream cyc %0d got %h@%h want %h@%h", cyc, inst, inst_pc, backing(exp_pc), exp_pc);
                end
                exp_pc = next_pc(exp_pc, backing(exp_pc));
                xfers++;
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
            step();
        end
        redirect_valid = 1'b0;
        n_vec++; if (xfers < 200) begin n_err++; $display("FAIL rand_progress got %0d transfers want >= 200", xfers); end
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        clear_cache();
        test_reset();
        test_cold_start();
        test_hit_stream();
        test_backpressure();
        test_redirect_miss();
        test_rdy_freeze();
        test_reset_mid_miss();
        test_jal();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Front-end fetch stage directly upstream of the instruction cache.
- Drives the instruction cache's combinational lookup with the current PC.
- On a miss, requests the word from the memory controller, fills the cache, then delivers the instruction.
- Presents one instruction per cycle on hits to the downstream instruction queue through a valid/ready handshake; accepts PC redirects from the commit/branch logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, PC and memory address width.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous active-low reset, sampled on the rising edge of clk_in.
- rdy_in  input  1  global ready; low freezes all state.
- ic_addr  output  32  cache lookup/fill address; bits [1:0] always 0.
- ic_hit  input  1  cache hit for ic_addr, combinational.
- ic_res  input  32  cached word for ic_addr.
- ic_we  output  1  cache write enable, one cycle per fill.
- ic_data  output  32  fill word.
- mem_req  output  1  memory fetch request, level, held until mem_done.
- mem_addr  output  32  word address of the request.
- mem_done  input  1  one-cycle pulse: mem_data valid, request complete.
- mem_data  input  32  fetched word.
- redirect_valid  input  1  flush and restart at redirect_pc.
- redirect_pc  input  32  new PC; bits [1:0] ignored and treated as 0.
- inst_valid  output  1  inst/inst_pc valid.
- inst_ready  input  1  downstream accepts this cycle.
- inst  output  32  instruction word.
- inst_pc  output  32  address of inst.

Behaviour:
- Reset (rst_in=0 at edge):
  - pc <= RESET_PC, state <= FETCH, pending-redirect flag cleared.
  - Outputs: inst_valid=0, inst=0, inst_pc=0, mem_req=0, mem_addr=0, ic_we=0, ic_data=0.
  - Reset in mid-miss abandons the request; a mem_done arriving after reset is ignored.
- rdy_in=0 (and not in reset): no register changes; ic_we forced 0; mem_req and all other outputs hold their values.
- Output register advance condition: adv = !inst_valid || inst_ready.
- Consumer handshake: a transfer occurs when inst_valid && inst_ready. If inst_ready=0, inst/inst_pc/inst_valid hold stable.
- State FETCH, combinational ic_addr = pc:
  - ic_hit && adv: inst <= ic_res, inst_pc <= pc, inst_valid <= 1, pc <= pc+4. Hit latency is 1 cycle; back-to-back hits give 1 instruction/cycle.
  - ic_hit && !adv: hold.
  - !ic_hit && adv: mem_req <= 1, mem_addr <= pc, state <= MISS. inst_valid clears if the current word was accepted.
  - !ic_hit && !adv: hold; the miss is not issued.
- State MISS, ic_addr = mem_addr:
  - Wait for mem_done. On the mem_done cycle: ic_we=1, ic_data=mem_data (combinational), mem_req <= 0, state <= FETCH.
  - The next FETCH cycle hits on the same PC. Miss-to-valid latency is 2 cycles after mem_done.
- Redirect (highest priority):
  - In FETCH: pc <= {redirect_pc[31:2],2'b00}, inst_valid <= 0, regardless of inst_ready or ic_hit.
  - In MISS: the memory transaction cannot be cancelled. Store the target in pend_pc and set the pending flag. On mem_done, still fill the cache, then pc <= pend_pc and return to FETCH.
  - Later redirects while pending overwrite pend_pc.
- pc+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 0.
- Same-cycle events:
  - Redirect and mem_done: the fill completes and pc <= redirect target.
  - Redirect and a consumer transfer: the transfer counts; inst_valid <= 0.

Optional Feature:
- Macro FETCH_JAL_PREDICT_EN.
- Defined:
  - A word delivered from ic_res whose opcode is 7'b1101111 (JAL) sets pc <= inst_pc + sign-extended J-immediate instead of pc+4.
  - The same applies to the post-fill hit.
  - Redirects still override.
- Undefined: always pc+4; no predecode logic is synthesised.

Decomposition:
- const.v holds:
  - RESET_PC default value.
  - Opcode constant OPC_JAL.
  - State encodings FETCH=1'b0, MISS=1'b1.
  - Existing ICACHE_SIZE_BIT.
- Sub-module fetch_predecode, present only under FETCH_JAL_PREDICT_EN:
  - Input: 32-bit word plus pc.
  - Outputs: is_jal and the 32-bit target.
  - Purely combinational.

Test Plan:
- Cold start:
  - Stimulus: reset release, empty cache, mem_done 5 cycles after mem_req with mem_data=32'h0000_0013.
  - Required response: mem_addr=0 and ic_we pulses once; 2 cycles after mem_done, inst_valid=1, inst=32'h13, inst_pc=0.
- Hit streaming:
  - Stimulus: words at 0,4,8,12 preloaded; inst_ready=1.
  - Required response: four consecutive cycles of inst_valid with inst_pc 0,4,8,12; mem_req stays 0.
- Backpressure:
  - Stimulus: inst_ready=0 for 3 cycles while a word is at inst_pc=4.
  - Required response: inst/inst_pc are stable; pc does not advance; no miss issued; the transfer completes on the first ready cycle.
- Redirect during miss:
  - Stimulus: redirect_valid with redirect_pc=32'h103 while in MISS at 32'h40.
  - Required response: the fill for 32'h40 still occurs; the next lookup is at 32'h100; no word from 32'h40 is delivered.
- rdy_in and reset:
  - Stimulus: rdy_in=0 for 4 cycles mid-miss with a mem_done arriving while rdy_in is low.
  - Required response: no state change and no cache write. Separately, rst_in=0 mid-miss gives mem_req=0, inst_valid=0, pc=RESET_PC.
- With FETCH_JAL_PREDICT_EN:
  - Stimulus: JAL x0,+16 at 32'h20.
  - Required response: the next inst_pc is 32'h30.
- Without FETCH_JAL_PREDICT_EN: the same stimulus gives next inst_pc 32'h24.
